gate_sweep_ctrl: RTL and testbench

Self-test sequencer for a small combinational gate under test, such as the NAND cell. On start, it drives every input vector 0..2^N_IN-1 onto the gate in ascending order. After each vector it waits a settle interval, samples the gate output and compares it against a programmed expected truth table. It then reports pass/fail, a mismatch count and the first failing vector. It is the hardware counterpart of a truth-table testbench and sits between a control/status register block and the gate instance.

---
 rtl/gate_sweep_ctrl_if.sv | 34 +++
 rtl/gate_sweep_ctrl.sv | 141 ++++++++++++++
 tb/tb_gate_sweep_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/gate_sweep_ctrl_if.sv
// Control/status and gate-side signal bundle for gate_sweep_ctrl.
//   start     : sweep request (sampled only while the controller is idle)
//   expected  : truth table, bit i = required gate output for vector i
//   gate_out  : output of the gate under test
//   gate_in   : vector driven to the gate (MSB = first operand)
//   busy      : sweep in progress
//   done      : sweep complete, level until next accepted start or reset
//   pass      : 1 iff the last sweep had no mismatches (valid with done)
//   fail_cnt  : number of mismatching vectors in the last sweep
//   fail_vec  : lowest-numbered failing vector of the last sweep
// master = register block / gate side, slave = the sweep controller.
interface gate_sweep_ctrl_if #(
    parameter int N_IN = 2
);
    logic                 start;
    logic [2**N_IN-1:0]   expected;
    logic                 gate_out;
    logic [N_IN-1:0]      gate_in;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [N_IN:0]        fail_cnt;
    logic [N_IN-1:0]      fail_vec;

    modport master (
        output start, expected, gate_out,
        input  gate_in, busy, done, pass, fail_cnt, fail_vec
    );

    modport slave (
        input  start, expected, gate_out,
        output gate_in, busy, done, pass, fail_cnt, fail_vec
    );
endinterface

// File: rtl/gate_sweep_ctrl.sv
// Self-test sequencer for a small combinational gate. On an accepted start it
// walks every input vector 0..2^N_IN-1 in ascending order, holds each for
// SETTLE cycles, samples the gate output for one cycle and compares it to the
// truth table captured at start. Reports pass, mismatch count and the first
// failing vector.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : gate_sweep_ctrl_if slave modport (control/status + gate signals)
module gate_sweep_ctrl #(
    parameter int N_IN   = 2,
    parameter int SETTLE = 2
) (
    input  logic                clk,
    input  logic                rst,
    gate_sweep_ctrl_if.slave    bus
);

    localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
    localparam logic [N_IN:0]   VEC_LAST = (N_IN + 1)'(2**N_IN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE
    } state_t;

    state_t               state_q,    state_d;
    logic [N_IN:0]        vec_q,      vec_d;
    logic [CW-1:0]        cnt_q,      cnt_d;
    logic [2**N_IN-1:0]   table_q,    table_d;
    logic                 first_q,    first_d;
    logic [N_IN-1:0]      gate_in_q,  gate_in_d;
    logic                 busy_q,     busy_d;
    logic                 done_q,     done_d;
    logic                 pass_q,     pass_d;
    logic [N_IN:0]        fail_cnt_q, fail_cnt_d;
    logic [N_IN-1:0]      fail_vec_q, fail_vec_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            vec_q      <= '0;
            cnt_q      <= '0;
            table_q    <= '0;
            first_q    <= 1'b0;
            gate_in_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_cnt_q <= '0;
            fail_vec_q <= '0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            cnt_q      <= cnt_d;
            table_q    <= table_d;
            first_q    <= first_d;
            gate_in_q  <= gate_in_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_cnt_q <= fail_cnt_d;
            fail_vec_q <= fail_vec_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        cnt_d      = cnt_q;
        table_d    = table_q;
        first_d    = first_q;
        gate_in_d  = gate_in_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        fail_cnt_d = fail_cnt_q;
        fail_vec_d = fail_vec_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    table_d    = bus.expected;
                    vec_d      = '0;
                    gate_in_d  = '0;
                    cnt_d      = '0;
                    fail_cnt_d = '0;
                    fail_vec_d = '0;
                    first_d    = 1'b0;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_SETTLE;
                end
            end

            S_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            S_SAMPLE: begin
                if (bus.gate_out != table_q[vec_q[N_IN-1:0]]) begin
                    fail_cnt_d = fail_cnt_q + (N_IN + 1)'(1);
                    if (!first_q) begin
                        fail_vec_d = vec_q[N_IN-1:0];
                        first_d    = 1'b1;
                    end
                end
                if (vec_q == VEC_LAST) begin
                    state_d   = S_IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    gate_in_d = '0;
                    // Uses the updated count so the final sample is included.
                    pass_d    = (fail_cnt_d == '0);
                end else begin
                    vec_d     = vec_q + (N_IN + 1)'(1);
                    gate_in_d = vec_d[N_IN-1:0];
                    state_d   = S_SETTLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign bus.gate_in  = gate_in_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
    assign bus.fail_cnt = fail_cnt_q;
    assign bus.fail_vec = fail_vec_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl (N_IN=2, SETTLE=2) with a NAND gate model
// that can be forced to a stuck-at-0 output.
module tb_gate_sweep_ctrl;

    localparam int N_IN   = 2;
    localparam int SETTLE = 2;
    localparam int HOLD   = SETTLE + 1;
    localparam int LAT    = (2**N_IN) * HOLD;

    logic clk;
    logic rst;
    logic stuck;
    int   n_total;
    int   n_bad;

    gate_sweep_ctrl_if #(.N_IN(N_IN)) bus ();

    gate_sweep_ctrl #(.N_IN(N_IN), .SETTLE(SETTLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    assign bus.gate_out = stuck ? 1'b0 : ~(bus.gate_in[1] & bus.gate_in[0]);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_gate_in"},  32'(bus.gate_in),  0);
        check({tag, "_busy"},     32'(bus.busy),     0);
        check({tag, "_done"},     32'(bus.done),     0);
        check({tag, "_pass"},     32'(bus.pass),     0);
        check({tag, "_fail_cnt"}, 32'(bus.fail_cnt), 0);
        check({tag, "_fail_vec"}, 32'(bus.fail_vec), 0);
    endtask

    // One full sweep with a single-cycle start pulse; checks latency, the
    // ascending vector sequence and the final results.
    task automatic run_sweep(input string tag, input logic [3:0] tbl,
                             input int exp_pass, input int exp_cnt, input int exp_vec);
        int cyc;
        int gerr;
        @(negedge clk);
        bus.expected = tbl;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({tag, "_busy_start"}, 32'(bus.busy), 1);
        check({tag, "_done_clr"},   32'(bus.done), 0);
        cyc  = 0;
        gerr = 0;
        while (!bus.done && cyc < 100) begin
            if (int'(bus.gate_in) != cyc / HOLD) gerr++;
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_latency"},  32'(cyc),          32'(LAT));
        check({tag, "_gate_seq"}, 32'(gerr),         0);
        check({tag, "_pass"},     32'(bus.pass),     32'(exp_pass));
        check({tag, "_fail_cnt"}, 32'(bus.fail_cnt), 32'(exp_cnt));
        check({tag, "_fail_vec"}, 32'(bus.fail_vec), 32'(exp_vec));
        check({tag, "_busy_end"}, 32'(bus.busy),     0);
        check({tag, "_gate_end"}, 32'(bus.gate_in),  0);
    endtask

    initial begin
        int ndone;
        int nerr;
        n_total      = 0;
        n_bad        = 0;
        stuck        = 1'b0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.expected = '0;

        #2;
        check_outputs_zero("reset");
        #21;
        rst = 1'b0;

        // NAND table matches
        run_sweep("nand_ok", 4'b0111, 1, 0, 0);
        // OR table against NAND: vectors 0 and 3 differ
        run_sweep("or_tbl", 4'b1110, 0, 2, 0);
        // single mismatch at vector 1
        run_sweep("one_fail", 4'b0101, 0, 1, 1);
        // every vector mismatches: fail_cnt at its maximum
        run_sweep("all_fail", 4'b1000, 0, 4, 0);

        // stuck-at-0 output, then recovery clears stale results
        stuck = 1'b1;
        run_sweep("stuck0", 4'b0111, 0, 3, 0);
        stuck = 1'b0;
        run_sweep("recover", 4'b0111, 1, 0, 0);

        // start re-pulses and expected change during a sweep are ignored
        @(negedge clk);
        bus.expected = 4'b0111;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        nerr = 0;
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            bus.start = (c == 3 || c == 7);
            if (c == 5) bus.expected = 4'b0000;
            @(posedge clk);
            #1;
            if (c < LAT && (bus.busy !== 1'b1 || bus.done !== 1'b0)) nerr++;
        end
        bus.start = 1'b0;
        check("ignore_busy_err", 32'(nerr),         0);
        check("ignore_done",     32'(bus.done),     1);
        check("ignore_pass",     32'(bus.pass),     1);
        check("ignore_fail_cnt", 32'(bus.fail_cnt), 0);

        // asynchronous reset during vector 2
        @(negedge clk);
        bus.expected = 4'b0111;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("rst_pre_vec", 32'(bus.gate_in), 2);
        #3;
        rst = 1'b1;
        #1;
        check_outputs_zero("rst_async");
        #7;
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) ndone++;
        end
        check("rst_no_done", 32'(ndone), 0);
        run_sweep("after_rst", 4'b0111, 1, 0, 0);

        // start held high: back-to-back sweeps, done one cycle each
        @(negedge clk);
        bus.expected = 4'b0111;
        bus.start    = 1'b1;
        ndone = 0;
        nerr  = 0;
        for (int t = 0; t < 40; t++) begin
            @(posedge clk);
            #1;
            if (bus.done !== (t == 12 || t == 25 || t == 38)) nerr++;
            if (bus.done) ndone++;
            if (t == 13) check("b2b_restart_busy", 32'(bus.busy), 1);
        end
        bus.start = 1'b0;
        check("b2b_done_cnt", 32'(ndone), 3);
        check("b2b_done_pos", 32'(nerr),  0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
